// File: rtl/module_bin2bcd_seq_if.sv
// Start/busy/done handshake and data bundle for the sequential binary-to-BCD converter.
// The master drives start/b; the converter (slave) returns the registered result and status.
interface module_bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      b;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  modport master (output start, b, input bcd, busy, done, ovf);
  modport slave  (input start, b, output bcd, busy, done, ovf);
endinterface

// File: rtl/module_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one operand bit per clock.
// Results that need more than DIGITS digits report ovf=1 with an all-zero bcd.
module module_bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic                  clk,
  input logic                  rst,
  module_bin2bcd_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    dig_q, dig_d;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    adj = dig_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end

    state_d  = state_q;
    dig_d    = dig_q;
    opr_d    = opr_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opr_d    = bus.b;
          dig_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CW'(WIDTH);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        dig_d    = {adj[BW-2:0], opr_q[WIDTH-1]};
        opr_d    = opr_q << 1;
        sticky_d = sticky_q | adj[BW-1];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          // Result registers load on the final shift so they are already valid while done is high.
          ovf_d   = sticky_d;
          bcd_d   = sticky_d ? '0 : dig_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dig_q    <= '0;
      opr_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      opr_q    <= opr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = (state_q == DONE);
  assign bus.busy = (state_q != IDLE);
endmodule
